// File: rtl/countdown_timer_if.sv
// Control and status bundle for the minutes:seconds countdown timer.
// The master side drives presets and strobes; the slave side is the timer itself.
interface countdown_timer_if #(
    parameter int MAX_MIN = 60,
    parameter int MAX_SEC = 60
);
    localparam int MW = $clog2(MAX_MIN);
    localparam int SW = $clog2(MAX_SEC);

    logic          sec_tick;
    logic          load;
    logic [MW-1:0] load_min;
    logic [SW-1:0] load_sec;
    logic          start;
    logic          pause;
    logic          clear;
    logic [MW-1:0] min_count;
    logic [SW-1:0] sec_count;
    logic          running;
    logic          done;
    logic          expired;

    modport master (
        output sec_tick, load, load_min, load_sec, start, pause, clear,
        input  min_count, sec_count, running, done, expired
    );

    modport slave (
        input  sec_tick, load, load_min, load_sec, start, pause, clear,
        output min_count, sec_count, running, done, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Down-counting minutes:seconds timer: loaded with a preset, decremented on each
// seconds tick while running, and flags expiry with a pulse plus a DONE level.
module countdown_timer #(
    parameter int MAX_MIN = 60,
    parameter int MAX_SEC = 60
) (
    input logic              clk,
    input logic              rst,
    countdown_timer_if.slave tmr
);
    localparam int MW = $clog2(MAX_MIN);
    localparam int SW = $clog2(MAX_SEC);
    localparam logic [MW-1:0] MIN_TOP = MW'(MAX_MIN - 1);
    localparam logic [SW-1:0] SEC_TOP = SW'(MAX_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] min_q, min_d;
    logic [SW-1:0] sec_q, sec_d;
    logic          expired_q, expired_d;
    logic          at_zero;

    assign at_zero = (min_q == '0) && (sec_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            expired_q <= expired_d;
        end
    end

    // Priority chain: an action that is not legal in the current state does not
    // consume the cycle, so the next lower-priority strobe may still act.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        expired_d = 1'b0;
        if (tmr.clear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
        end else if (tmr.load && state_q != RUN) begin
            state_d = IDLE;
            min_d   = (tmr.load_min > MIN_TOP) ? MIN_TOP : tmr.load_min;
            sec_d   = (tmr.load_sec > SEC_TOP) ? SEC_TOP : tmr.load_sec;
        end else if (tmr.pause && state_q == RUN) begin
            state_d = PAUSED;
        end else if (tmr.start && (state_q == IDLE || state_q == PAUSED) && !at_zero) begin
            state_d = RUN;
        end else if (tmr.sec_tick && state_q == RUN) begin
            if (sec_q != '0) begin
                sec_d = sec_q - SW'(1);
                if (sec_q == SW'(1) && min_q == '0) begin
                    state_d   = DONE;
                    expired_d = 1'b1;
                end
            end else if (min_q != '0) begin
                sec_d = SEC_TOP;
                min_d = min_q - MW'(1);
            end
        end
    end

    assign tmr.min_count = min_q;
    assign tmr.sec_count = sec_q;
    assign tmr.running   = (state_q == RUN);
    assign tmr.done      = (state_q == DONE);
    assign tmr.expired   = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: a remaining-seconds model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_countdown_timer;
    localparam int MAX_MIN = 60;
    localparam int MAX_SEC = 60;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    typedef struct packed {
        int rem;
        int mode;
        bit exp;
    } mdl_t;

    logic clk;
    logic rst;
    int   assert_count;
    int   fail_count;
    bit   checking;
    mdl_t m;

    countdown_timer_if #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) tmr ();

    countdown_timer #(.MAX_MIN(MAX_MIN), .MAX_SEC(MAX_SEC)) dut (
        .clk (clk),
        .rst (rst),
        .tmr (tmr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampi(int v, int top);
        return (v > top) ? top : v;
    endfunction

    // Reference behaviour: the timer is just a count of remaining seconds plus a mode.
    function automatic mdl_t step(mdl_t cur, bit r, bit clr, bit ld, int lmin, int lsec,
                                  bit ps, bit st, bit tk);
        mdl_t n;
        n = cur;
        n.exp = 1'b0;
        if (r) begin
            n.rem  = 0;
            n.mode = M_IDLE;
        end else if (clr) begin
            n.rem  = 0;
            n.mode = M_IDLE;
        end else if (ld && cur.mode != M_RUN) begin
            n.rem  = clampi(lmin, MAX_MIN - 1) * MAX_SEC + clampi(lsec, MAX_SEC - 1);
            n.mode = M_IDLE;
        end else if (ps && cur.mode == M_RUN) begin
            n.mode = M_PAUSED;
        end else if (st && (cur.mode == M_IDLE || cur.mode == M_PAUSED) && cur.rem > 0) begin
            n.mode = M_RUN;
        end else if (tk && cur.mode == M_RUN) begin
            n.rem = cur.rem - 1;
            if (n.rem == 0) begin
                n.mode = M_DONE;
                n.exp  = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m, rst, tmr.clear, tmr.load, int'(tmr.load_min), int'(tmr.load_sec),
                  tmr.pause, tmr.start, tmr.sec_tick);
    end

    always @(negedge clk) begin
        if (checking) begin
            assert_count++;
            if (int'(tmr.min_count) != m.rem / MAX_SEC || int'(tmr.sec_count) != m.rem % MAX_SEC ||
                tmr.running != (m.mode == M_RUN) || tmr.done != (m.mode == M_DONE) ||
                tmr.expired != m.exp) begin
                fail_count++;
                $display("[TB] FAIL model_cycle t=%0t: got %0d:%0d run=%0b done=%0b exp=%0b, want %0d:%0d run=%0b done=%0b exp=%0b",
                         $time, tmr.min_count, tmr.sec_count, tmr.running, tmr.done, tmr.expired,
                         m.rem / MAX_SEC, m.rem % MAX_SEC, m.mode == M_RUN, m.mode == M_DONE, m.exp);
            end
        end
    end

    task automatic applyStimulus(input bit r, input bit clr, input bit ld, input int lmin,
                                 input int lsec, input bit ps, input bit st, input bit tk);
        rst          = r;
        tmr.clear    = clr;
        tmr.load     = ld;
        tmr.load_min = 6'(lmin);
        tmr.load_sec = 6'(lsec);
        tmr.pause    = ps;
        tmr.start    = st;
        tmr.sec_tick = tk;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        tmr.clear    = 1'b0;
        tmr.load     = 1'b0;
        tmr.pause    = 1'b0;
        tmr.start    = 1'b0;
        tmr.sec_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic loadPreset(input int lmin, input int lsec);
        applyStimulus(0, 0, 1, lmin, lsec, 0, 0, 0);
    endtask

    task automatic startTimer();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic checkOutput(input string name, input int emin, input int esec,
                               input bit erun, input bit edone, input bit eexp);
        assert_count++;
        if (int'(tmr.min_count) != emin || int'(tmr.sec_count) != esec ||
            tmr.running != erun || tmr.done != edone || tmr.expired != eexp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d:%0d run=%0b done=%0b exp=%0b, want %0d:%0d run=%0b done=%0b exp=%0b",
                     name, tmr.min_count, tmr.sec_count, tmr.running, tmr.done, tmr.expired,
                     emin, esec, erun, edone, eexp);
        end
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        checking     = 1'b0;
        m            = '0;
        rst          = 1'b1;
        tmr.clear    = 1'b0;
        tmr.load     = 1'b0;
        tmr.load_min = '0;
        tmr.load_sec = '0;
        tmr.pause    = 1'b0;
        tmr.start    = 1'b0;
        tmr.sec_tick = 1'b0;

        // Reset then idle ticks
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checking = 1'b1;
        checkOutput("reset_state", 0, 0, 0, 0, 0);
        ticks(100);
        checkOutput("idle_ticks", 0, 0, 0, 0, 0);

        // Full countdown from 01:02 with borrow
        loadPreset(1, 2);
        checkOutput("load_0102", 1, 2, 0, 0, 0);
        startTimer();
        checkOutput("start_run", 1, 2, 1, 0, 0);
        ticks(1);
        checkOutput("tick1", 1, 1, 1, 0, 0);
        ticks(2);
        checkOutput("tick3_borrow", 0, 59, 1, 0, 0);
        ticks(58);
        checkOutput("tick61", 0, 1, 1, 0, 0);
        ticks(1);
        checkOutput("tick62_expired", 0, 0, 0, 1, 1);
        idle(1);
        checkOutput("expired_once", 0, 0, 0, 1, 0);
        ticks(5);
        startTimer();
        checkOutput("done_holds", 0, 0, 0, 1, 0);

        // Pause/resume, pause drops a coincident tick
        loadPreset(0, 10);
        startTimer();
        ticks(3);
        checkOutput("pause_pre", 0, 7, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1);
        checkOutput("pause_with_tick", 0, 7, 0, 0, 0);
        ticks(5);
        checkOutput("paused_holds", 0, 7, 0, 0, 0);
        startTimer();
        ticks(6);
        checkOutput("resume_tick6", 0, 1, 1, 0, 0);
        ticks(1);
        checkOutput("resume_done", 0, 0, 0, 1, 1);
        idle(2);

        // Clamping and zero start
        loadPreset(63, 63);
        checkOutput("clamp", 59, 59, 0, 0, 0);
        loadPreset(0, 0);
        startTimer();
        checkOutput("zero_start", 0, 0, 0, 0, 0);
        idle(2);

        // Start and tick on the same edge: tick not counted
        loadPreset(0, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("start_tick_same", 0, 3, 1, 0, 0);
        ticks(1);
        checkOutput("first_tick_after", 0, 2, 1, 0, 0);

        // Priority cases
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        loadPreset(0, 5);
        startTimer();
        loadPreset(0, 30);
        checkOutput("load_in_run", 0, 5, 1, 0, 0);
        ticks(1);
        checkOutput("keeps_counting", 0, 4, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0);
        checkOutput("clear_start", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 2, 0, 1, 0);
        checkOutput("load_start", 0, 2, 0, 0, 0);

        // Reset mid-run with a coincident tick
        loadPreset(0, 1);
        startTimer();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("reset_mid_run", 0, 0, 0, 0, 0);
        idle(3);
        checkOutput("reset_no_expiry", 0, 0, 0, 0, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting minutes:seconds timer for the clock design. It is the decrementing counterpart of the up-counting time counters.
- Loaded with a preset, then decremented once per seconds tick from the tick generator.
- Signals expiry with a one-cycle pulse plus a level flag.
- Feeds the alarm/buzzer logic and the display mux.

Parameters:
- MAX_MIN, 60, minutes modulus; minutes range 0..MAX_MIN-1; must be >= 2.
- MAX_SEC, 60, seconds modulus; seconds range 0..MAX_SEC-1; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sec_tick  input  1  one-cycle pulse, once per second.
- load  input  1  load-preset strobe.
- load_min  input  $clog2(MAX_MIN)  preset minutes.
- load_sec  input  $clog2(MAX_SEC)  preset seconds.
- start  input  1  start/resume strobe.
- pause  input  1  pause strobe.
- clear  input  1  abort; zero the counts.
- min_count  output  $clog2(MAX_MIN)  remaining minutes.
- sec_count  output  $clog2(MAX_SEC)  remaining seconds.
- running  output  1  high only in state RUN.
- done  output  1  high only in state DONE.
- expired  output  1  one-cycle pulse on reaching 00:00 from RUN.

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered or decoded from registered state.
  - The reset (`rst`) is synchronous and active-high.
  - On reset: state=IDLE, min_count=0, sec_count=0, running=0, done=0, expired=0.
- States: IDLE, RUN, PAUSED, DONE.
- Per-cycle priority: rst > clear > load > pause > start > sec_tick. At most one control action takes effect per cycle.
- clear (any state): state→IDLE, counts→0, expired=0.
- load:
  - In IDLE, PAUSED or DONE: counts←preset, state→IDLE.
  - Clamping: load_min >= MAX_MIN stores MAX_MIN-1; load_sec >= MAX_SEC stores MAX_SEC-1.
  - In RUN: load is ignored.
- start:
  - In IDLE or PAUSED with count != 00:00: state→RUN.
  - With count == 00:00: no state change, no expired.
  - In RUN or DONE: ignored.
- pause:
  - In RUN: state→PAUSED. A sec_tick in the same cycle is dropped; no decrement.
  - In other states: ignored.
- Decrement (RUN only, on sec_tick):
  - sec_count > 0: sec_count-1.
  - sec_count == 0 and min_count > 0: sec_count←MAX_SEC-1, min_count-1 (borrow).
  - The decrement that produces 00:00 also moves state→DONE on the same edge.
  - expired is high for exactly the first cycle in DONE (registered; one cycle after the final tick's edge).
- sec_tick outside RUN has no effect. Counts hold in IDLE, PAUSED and DONE.
- DONE:
  - Counts hold at 00:00; done=1.
  - Exit only via clear or load; start is ignored.
  - expired never re-fires while in DONE.
- Boundary cases:
  - sec_tick on the same edge that start enters RUN: not counted. The first decrement occurs on the first sec_tick strictly after RUN is entered.
  - Back-to-back sec_tick on consecutive cycles: each one decrements.
  - rst mid-RUN: immediate return to reset values; a pending expired is suppressed.
- Width rule:
  - No arithmetic wraps below 0.
  - Counts never exceed MAX-1.
  - Comparisons are done at full port width.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 100 sec_ticks with no start → min_count=0, sec_count=0, running=0, done=0, expired never asserted.
- Full countdown: load 01:02, start, 62 sec_ticks → after tick 1 reads 01:01; after tick 3 reads 00:59 (borrow); after tick 62 reads 00:00 with done=1. expired is high exactly one cycle, one cycle after tick 62's edge. Further ticks leave 00:00, with expired staying 0.
- Pause/resume: load 00:10, start, 3 ticks → 00:07. Then pause together with a sec_tick in the same cycle → 00:07, running=0. 5 ticks while PAUSED → still 00:07. start, 7 ticks → 00:00 with DONE and one expired pulse.
- Clamp and zero start: load_min=63, load_sec=63 (with MAX=60) → 59:59. Then load 00:00 and start → stays IDLE, running=0, no expired.
- Priority: in RUN at 00:05, assert load=1 (00:30) → ignored, keeps counting. Assert clear+start together → IDLE at 00:00. Assert load 00:02 + start in the same cycle → IDLE 00:02, not RUN.
- Reset mid-run: load 00:01, start, sec_tick with rst=1 on the same edge → 00:00 in IDLE, done=0, expired=0 on all following cycles.
